cpu_wb_bridge: RTL

Wishbone master bridge that turns the external host CPU's asynchronous 8-bit SRAM-style bus (`addr`, `sram_data`, `nwe`, `noe`, `ncs`) into single-byte Wishbone transfers. It sits upstream of the Wishbone interconnect on a spare master port (m2) and gives the host direct access to the SoC address space. The main uses are loading firmware into block RAM while the LM32 is held in reset, and mailbox access to peripherals.

---
 rtl/cpu_wb_bridge_if.sv | 54 +++++
 rtl/cpu_wb_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_wb_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_wb_bridge_if
//  Description : Wishbone bus bundle between cpu_wb_bridge (master) and the
//                interconnect master port it drives (slave side).
//
//  Signals (named from the master's point of view):
//    wb_adr_o  [31:0]  byte address
//    wb_dat_o  [31:0]  write data
//    wb_dat_i  [31:0]  read data
//    wb_sel_o  [3:0]   byte select
//    wb_we_o           write enable
//    wb_cyc_o          cycle
//    wb_stb_o          strobe
//    wb_ack_i          acknowledge
//
//  Modports    : master - bridge side, slave - interconnect / target side
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_wb_bridge_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o,
        output wb_dat_o,
        output wb_sel_o,
        output wb_we_o,
        output wb_cyc_o,
        output wb_stb_o,
        input  wb_dat_i,
        input  wb_ack_i
    );

    modport slave (
        input  wb_adr_o,
        input  wb_dat_o,
        input  wb_sel_o,
        input  wb_we_o,
        input  wb_cyc_o,
        input  wb_stb_o,
        output wb_dat_i,
        output wb_ack_i
    );

endinterface
`default_nettype wire

// File: rtl/cpu_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_wb_bridge
//  Description : Host-CPU to Wishbone master bridge. Converts the host's
//                asynchronous 8-bit SRAM-style strobes into single-byte
//                Wishbone transfers (big-endian lane mapping). Used for
//                firmware download into block RAM and mailbox accesses.
//
//  Parameters  :
//    BASE_ADR  Wishbone byte address that host address 0 maps to
//    TIMEOUT   Wishbone cycles to wait for ack before aborting (1..65535)
//
//  Ports       :
//    clk           system clock
//    rst           synchronous reset, active low
//    addr[12:0]    host byte address (asynchronous)
//    sram_data     host write data (asynchronous)
//    noe/nwe/ncs   host strobes, active low (asynchronous)
//    sram_data_o   read data returned to the host
//    sram_data_oe  pad drive enable (synchronized ncs and noe both low)
//    wb            Wishbone master bundle (cpu_wb_bridge_if.master)
//    busy          a Wishbone cycle is outstanding
//    err           sticky: timeout or dropped host access
//    overrun       sticky: host access arrived while busy
//
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_wb_bridge #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  wire         clk,
    input  wire         rst,

    // Host SRAM-style bus
    input  wire  [12:0] addr,
    input  wire  [7:0]  sram_data,
    input  wire         noe,
    input  wire         nwe,
    input  wire         ncs,
    output logic [7:0]  sram_data_o,
    output logic        sram_data_oe,

    // Wishbone master
    cpu_wb_bridge_if.master wb,

    // Status
    output logic        busy,
    output logic        err,
    output logic        overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_WRITE = 2'd1;
    localparam logic [1:0]  c_ST_READ  = 2'd2;

    localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT);

    // ------------------------------------------------------------------------
    // Strobe synchronizers
    //   [0] metastability stage, [1] synchronized value, [2] previous value.
    //   ncs only qualifies events, so it needs no edge-history stage.
    // ------------------------------------------------------------------------
    logic [1:0] ncs_q;
    logic [2:0] nwe_q;
    logic [2:0] noe_q;

    logic w_ncs_s;
    logic w_nwe_s;
    logic w_nwe_p;
    logic w_noe_s;
    logic w_noe_p;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ncs_q <= 2'b11;
            nwe_q <= 3'b111;
            noe_q <= 3'b111;
        end else begin
            ncs_q <= {ncs_q[0], ncs};
            nwe_q <= {nwe_q[1:0], nwe};
            noe_q <= {noe_q[1:0], noe};
        end
    end

    assign w_ncs_s = ncs_q[1];
    assign w_nwe_s = nwe_q[1];
    assign w_nwe_p = nwe_q[2];
    assign w_noe_s = noe_q[1];
    assign w_noe_p = noe_q[2];

    // ------------------------------------------------------------------------
    // Host event detection
    //   Write completes on the trailing (rising) edge of nwe, read starts on
    //   the leading (falling) edge of noe; both only count with ncs low.
    //   Events are registered so the FSM sees them one clock later.
    // ------------------------------------------------------------------------
    logic w_wr_evt;
    logic w_rd_evt;
    logic wr_evt_q;
    logic rd_evt_q;

    assign w_wr_evt = ~w_ncs_s &  w_nwe_s & ~w_nwe_p;
    assign w_rd_evt = ~w_ncs_s & ~w_noe_s &  w_noe_p;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_evt_q <= 1'b0;
            rd_evt_q <= 1'b0;
        end else begin
            wr_evt_q <= w_wr_evt;
            rd_evt_q <= w_rd_evt;
        end
    end

    // ------------------------------------------------------------------------
    // Host address / data capture
    //   Write capture runs continuously while the write strobe is low, so the
    //   value held when nwe rises is the last stable one the host presented.
    //   Read address is taken on the read-event cycle itself.
    // ------------------------------------------------------------------------
    logic [12:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [12:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr_q <= 13'd0;
            wr_data_q <= 8'd0;
            rd_addr_q <= 13'd0;
        end else begin
            if (~w_ncs_s & ~w_nwe_s) begin
                wr_addr_q <= addr;
                wr_data_q <= sram_data;
            end
            if (w_rd_evt) begin
                rd_addr_q <= addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [15:0] cnt_q;
    logic [15:0] w_cnt_inc;
    logic        w_busy;
    logic        w_ack;
    logic        w_tmo;
    logic        w_start_wr;
    logic        w_start_rd;
    logic        w_start;
    logic        w_flag_ovr;
    logic        w_rd_done;
    logic        w_rd_tmo;

    assign w_busy     = (state_q != c_ST_IDLE);
    assign w_ack      = w_busy & wb.wb_ack_i;
    assign w_cnt_inc  = cnt_q + 16'd1;
    // Abort once this busy cycle would bring the wait count up to TIMEOUT.
    assign w_tmo      = w_busy & ~wb.wb_ack_i & (w_cnt_inc == c_TIMEOUT);

    // Write takes priority over a simultaneous read.
    assign w_start_wr = ~w_busy & wr_evt_q;
    assign w_start_rd = ~w_busy & rd_evt_q & ~wr_evt_q;
    assign w_start    = w_start_wr | w_start_rd;

    // Any event that cannot be served is dropped and flagged.
    assign w_flag_ovr = (w_busy & (wr_evt_q | rd_evt_q)) |
                        (~w_busy & wr_evt_q & rd_evt_q);

    assign w_rd_done  = (state_q == c_ST_READ) & wb.wb_ack_i;
    assign w_rd_tmo   = (state_q == c_ST_READ) & w_tmo;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (wr_evt_q) begin
                    state_d = c_ST_WRITE;
                end else if (rd_evt_q) begin
                    state_d = c_ST_READ;
                end
            end
            c_ST_WRITE,
            c_ST_READ: begin
                if (w_ack || w_tmo) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (decoded from the registered state only)
    // ------------------------------------------------------------------------
    logic w_cyc;
    logic w_we;

    always_comb begin
        w_cyc = 1'b0;
        w_we  = 1'b0;
        case (state_q)
            c_ST_WRITE: begin
                w_cyc = 1'b1;
                w_we  = 1'b1;
            end
            c_ST_READ: begin
                w_cyc = 1'b1;
            end
            default: begin
                w_cyc = 1'b0;
                w_we  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Wishbone address / lane generation
    //   Host byte lanes are big-endian: byte 0 lives in bits [31:24].
    // ------------------------------------------------------------------------
    logic [12:0] w_src_addr;
    logic [31:0] w_adr_d;
    logic [3:0]  w_sel_d;

    assign w_src_addr = w_start_wr ? wr_addr_q : rd_addr_q;
    assign w_adr_d    = BASE_ADR + {19'b0, w_src_addr[12:2], 2'b00};
    assign w_sel_d    = 4'b1000 >> w_src_addr[1:0];

    // ------------------------------------------------------------------------
    // Read lane extraction
    // ------------------------------------------------------------------------
    logic [1:0] lane_q;
    logic [7:0] w_lane;

    always_comb begin
        w_lane = 8'h00;
        case (lane_q)
            2'd0:    w_lane = wb.wb_dat_i[31:24];
            2'd1:    w_lane = wb.wb_dat_i[23:16];
            2'd2:    w_lane = wb.wb_dat_i[15:8];
            default: w_lane = wb.wb_dat_i[7:0];
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------------
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [7:0]  rdata_q;
    logic        err_q;
    logic        ovr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            lane_q  <= 2'd0;
            cnt_q   <= 16'd0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (w_start) begin
                adr_q  <= w_adr_d;
                sel_q  <= w_sel_d;
                lane_q <= w_src_addr[1:0];
            end
            if (w_start_wr) begin
                dat_q <= {4{wr_data_q}};
            end

            if (w_start) begin
                cnt_q <= 16'd0;
            end else if (w_busy) begin
                cnt_q <= w_cnt_inc;
            end

            // A read that times out returns all-ones so the host sees a
            // recognisable "no device" value.
            if (w_rd_done) begin
                rdata_q <= w_lane;
            end else if (w_rd_tmo) begin
                rdata_q <= 8'hFF;
            end

            if (w_flag_ovr) begin
                ovr_q <= 1'b1;
            end
            if (w_flag_ovr || w_tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wb.wb_adr_o  = adr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_we_o   = w_we;
    assign wb.wb_cyc_o  = w_cyc;
    assign wb.wb_stb_o  = w_cyc;

    assign sram_data_o  = rdata_q;
    assign sram_data_oe = ~w_ncs_s & ~w_noe_s;

    assign busy         = w_busy;
    assign err          = err_q;
    assign overrun      = ovr_q;

endmodule
`default_nettype wire
